// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing generator.
// Registers an incoming VGA stream (HS, VS, BLANK, 4:4:4 RGB), recovers the
// pixel X/Y and the linear frame-buffer address, verifies line/period/frame
// timing, and once a clean frame has been seen emits one write strobe per
// visible pixel.
//
// Ports:
//   iCLK, iRST            pixel clock, asynchronous active-high reset
//   iVGA_HS, iVGA_VS      syncs, active low
//   iVGA_BLANK            high = visible pixel
//   iVGA_R/G/B            pixel colour
//   oRed/oGreen/oBlue     registered colour, valid with oWrite
//   oCurrent_X/Y          coordinates of the pixel on the output stage
//   oAddress              oCurrent_Y*H_ACT + oCurrent_X
//   oWrite                one strobe per captured pixel
//   oFrameStart           pulse per VS falling edge
//   oLocked               stream verified, captures enabled
//   oError                pulse on a timing violation while locked
module vga_capture #(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned H_TOTAL = 800
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iVGA_HS,
  input  logic        iVGA_VS,
  input  logic        iVGA_BLANK,
  input  logic [3:0]  iVGA_R,
  input  logic [3:0]  iVGA_G,
  input  logic [3:0]  iVGA_B,
  output logic [3:0]  oRed,
  output logic [3:0]  oGreen,
  output logic [3:0]  oBlue,
  output logic [9:0]  oCurrent_X,
  output logic [9:0]  oCurrent_Y,
  output logic [21:0] oAddress,
  output logic        oWrite,
  output logic        oFrameStart,
  output logic        oLocked,
  output logic        oError
);

  localparam logic [9:0]  H_ACT_C   = 10'(H_ACT);
  localparam logic [9:0]  V_ACT_C   = 10'(V_ACT);
  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  // stage 1 and its previous value for edge detection
  logic        hs1_q, vs1_q, bl1_q, hsp_q, vsp_q, blp_q;
  logic [11:0] rgb1_q;

  logic [9:0]  pix_q, pix_d, pix_base, line_q, line_d, line_inc;
  logic        over_q, over_d, over_base;
  logic [10:0] per_q, per_d;
  logic [11:0] per_len;
  logic        first_q, first_d, fok_q, fok_d;
  state_t      state_q, state_d;

  logic        hs_fall, vs_fall, bl_rise, bl_fall;
  logic        line_bad, per_bad, frame_bad;
  logic        err_d, wr_d;
  logic [9:0]  x_d, y_d;
  logic [21:0] addr_d;
  logic [11:0] rgb_d;

  always_comb begin
    hs_fall = hsp_q & ~hs1_q;
    vs_fall = vsp_q & ~vs1_q;
    bl_rise = ~blp_q & bl1_q;
    bl_fall = blp_q & ~bl1_q;

    // the line-start sample sees a cleared counter, so its X is 0
    pix_base  = bl_rise ? '0 : pix_q;
    over_base = bl_rise ? 1'b0 : over_q;
    pix_d     = pix_base;
    over_d    = over_base;
    if (bl1_q) begin
      if (pix_base == H_ACT_C) over_d = 1'b1;
      else                     pix_d  = pix_base + 10'd1;
    end

    line_inc = (bl_fall && line_q != '1) ? line_q + 10'd1 : line_q;
    line_d   = vs_fall ? '0 : line_inc;

    per_d   = hs_fall ? '0 : ((per_q == '1) ? per_q : per_q + 11'd1);
    per_len = {1'b0, per_q} + 12'd1;

    line_bad = bl_fall && ((pix_q != H_ACT_C) || over_q);
    // an HS fall coinciding with VS fall counts as the first one of the frame
    per_bad  = hs_fall && !first_q && !vs_fall && (per_len != H_TOTAL_C);
    // line_inc folds in a BLANK fall landing on the same sample as VS fall
    frame_bad = vs_fall && ((line_inc != V_ACT_C) || !fok_q || line_bad || per_bad);

    if (vs_fall)      first_d = !hs_fall;
    else if (hs_fall) first_d = 1'b0;
    else              first_d = first_q;

    if (vs_fall)                   fok_d = 1'b1;
    else if (line_bad || per_bad)  fok_d = 1'b0;
    else                           fok_d = fok_q;

    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH:  if (vs_fall) state_d = MEASURE;
      MEASURE: if (vs_fall && !frame_bad) state_d = LOCKED;
      LOCKED: begin
        if (line_bad || per_bad || frame_bad) begin
          err_d   = 1'b1;
          state_d = MEASURE;
        end
      end
      default: state_d = SEARCH;
    endcase

    wr_d = bl1_q && (state_q == LOCKED) && !err_d &&
           (pix_base < H_ACT_C) && (line_q < V_ACT_C);

    x_d    = wr_d ? pix_base : oCurrent_X;
    y_d    = wr_d ? line_q   : oCurrent_Y;
    addr_d = wr_d ? (22'(line_q) * 22'(H_ACT) + 22'(pix_base)) : oAddress;
    rgb_d  = wr_d ? rgb1_q : {oRed, oGreen, oBlue};
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      bl1_q       <= 1'b0;
      hsp_q       <= 1'b0;
      vsp_q       <= 1'b0;
      blp_q       <= 1'b0;
      rgb1_q      <= '0;
      pix_q       <= '0;
      over_q      <= 1'b0;
      line_q      <= '0;
      per_q       <= '0;
      first_q     <= 1'b0;
      fok_q       <= 1'b0;
      state_q     <= SEARCH;
      oWrite      <= 1'b0;
      oFrameStart <= 1'b0;
      oError      <= 1'b0;
      oLocked     <= 1'b0;
      oCurrent_X  <= '0;
      oCurrent_Y  <= '0;
      oAddress    <= '0;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
    end else begin
      hs1_q       <= iVGA_HS;
      vs1_q       <= iVGA_VS;
      bl1_q       <= iVGA_BLANK;
      hsp_q       <= hs1_q;
      vsp_q       <= vs1_q;
      blp_q       <= bl1_q;
      rgb1_q      <= {iVGA_R, iVGA_G, iVGA_B};
      pix_q       <= pix_d;
      over_q      <= over_d;
      line_q      <= line_d;
      per_q       <= per_d;
      first_q     <= first_d;
      fok_q       <= fok_d;
      state_q     <= state_d;
      oWrite      <= wr_d;
      oFrameStart <= vs_fall;
      oError      <= err_d;
      oLocked     <= (state_d == LOCKED);
      oCurrent_X  <= x_d;
      oCurrent_Y  <= y_d;
      oAddress    <= addr_d;
      {oRed, oGreen, oBlue} <= rgb_d;
    end
  end

endmodule
